bip_program_loader: RTL and testbench

Fills BIP1 program memory from a byte stream (UART receiver output) before the CPU runs. Packs byte pairs into 16-bit instruction words ({opcode, operand}), checks each opcode against the 8-instruction BIP1 ISA, and writes words to sequential program-memory addresses. It sits between the UART RX and program memory; the instruction decoder later consumes exactly these words. It asserts `prog_done` once a Halt word is stored, which releases the CPU from reset.

---
 rtl/bip_pkg.sv | 29 ++
 rtl/bip_loader_timer.sv | 30 +++
 rtl/bip_program_loader.sv | 121 ++++++++++++
 tb/tb_bip_program_loader.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/bip_pkg.sv
// Shared BIP1 definitions: ISA opcodes, instruction field widths and loader states.
package bip_pkg;

    localparam int unsigned LEN_OPCODE  = 5;
    localparam int unsigned LEN_OPERAND = 11;

    localparam logic [LEN_OPCODE-1:0] OP_HLT  = 5'd0;
    localparam logic [LEN_OPCODE-1:0] OP_STO  = 5'd1;
    localparam logic [LEN_OPCODE-1:0] OP_LD   = 5'd2;
    localparam logic [LEN_OPCODE-1:0] OP_LDI  = 5'd3;
    localparam logic [LEN_OPCODE-1:0] OP_ADD  = 5'd4;
    localparam logic [LEN_OPCODE-1:0] OP_ADDI = 5'd5;
    localparam logic [LEN_OPCODE-1:0] OP_SUB  = 5'd6;
    localparam logic [LEN_OPCODE-1:0] OP_SUBI = 5'd7;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WAIT_LO = 3'd1,
        ST_WRITE   = 3'd2,
        ST_DONE    = 3'd3,
        ST_ERROR   = 3'd4
    } loader_state_e;

    // The BIP1 ISA occupies opcodes 0..7; anything above is not an instruction.
    function automatic logic is_valid_opcode(input logic [LEN_OPCODE-1:0] op);
        return op <= OP_SUBI;
    endfunction

endpackage

// File: rtl/bip_loader_timer.sv
// Loadable/clearable up-counter whose terminal flag marks the inter-byte timeout.
module bip_loader_timer #(
    parameter int unsigned terminal = 50000
) (
    input  logic                                 i_clk,
    input  logic                                 i_reset,
    input  logic                                 i_clear,
    input  logic                                 i_load,
    input  logic [$clog2(terminal+1)-1:0]        i_load_val,
    input  logic                                 i_en,
    output logic                                 o_tc_c
);

    localparam int unsigned CW = $clog2(terminal + 1);

    logic [CW-1:0] r_count;

    always_ff @(posedge i_clk) begin
        if (!i_reset || i_clear) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_en) begin
            r_count <= r_count + CW'(1);
        end
    end

    assign o_tc_c = (r_count == CW'(terminal - 1));

endmodule

// File: rtl/bip_program_loader.sv
// Packs received byte pairs into BIP1 instruction words and writes them to program memory.
module bip_program_loader
    import bip_pkg::*;
#(
    parameter int unsigned len_opcode     = LEN_OPCODE,
    parameter int unsigned len_operand    = LEN_OPERAND,
    parameter int unsigned len_addr       = 11,
    parameter int unsigned len_byte       = 8,
    parameter int unsigned timeout_cycles = 50000
) (
    input  logic                            i_clk,
    input  logic                            i_reset,
    input  logic [len_byte-1:0]             i_rx_data,
    input  logic                            i_rx_done,
    output logic                            o_wr_en,
    output logic [len_addr-1:0]             o_wr_addr,
    output logic [len_opcode+len_operand-1:0] o_wr_data,
    output logic                            o_loading,
    output logic                            o_prog_done,
    output logic                            o_load_err
);

    localparam int unsigned WORD_W = len_opcode + len_operand;
    localparam int unsigned TCW    = $clog2(timeout_cycles + 1);

    loader_state_e       r_state;
    logic [WORD_W-1:0]   r_word;
    logic [WORD_W-1:0]   r_wr_data;
    logic [len_addr-1:0] r_addr;
    logic                r_wr_en;
    logic                r_loading;
    logic                r_prog_done;
    logic                r_load_err;

    logic w_clear;
    logic w_en;
    logic w_tc;

    assign w_clear = (r_state == ST_IDLE) && i_rx_done;
    assign w_en    = (r_state == ST_WAIT_LO);

    bip_loader_timer #(
        .terminal (timeout_cycles)
    ) u_timer (
        .i_clk      (i_clk),
        .i_reset    (i_reset),
        .i_clear    (w_clear),
        .i_load     (1'b0),
        .i_load_val ({TCW{1'b0}}),
        .i_en       (w_en),
        .o_tc_c     (w_tc)
    );

    // WRITE spans two cycles: the first raises wr_en, the second retires the word.
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_state     <= ST_IDLE;
            r_word      <= '0;
            r_wr_data   <= '0;
            r_addr      <= '0;
            r_wr_en     <= 1'b0;
            r_loading   <= 1'b1;
            r_prog_done <= 1'b0;
            r_load_err  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (i_rx_done) begin
                        r_word[WORD_W-1 -: len_byte] <= i_rx_data;
                        r_state                      <= ST_WAIT_LO;
                    end
                end
                ST_WAIT_LO: begin
                    if (i_rx_done) begin
                        r_word[len_byte-1:0] <= i_rx_data;
                        if (is_valid_opcode(LEN_OPCODE'(r_word[WORD_W-1 -: len_opcode]))) begin
                            r_state <= ST_WRITE;
                        end else begin
                            r_load_err <= 1'b1;
                            r_loading  <= 1'b0;
                            r_state    <= ST_ERROR;
                        end
                    end else if (w_tc) begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_WRITE: begin
                    if (!r_wr_en) begin
                        r_wr_en   <= 1'b1;
                        r_wr_data <= r_word;
                    end else begin
                        r_wr_en <= 1'b0;
                        r_addr  <= r_addr + len_addr'(1);
                        if (LEN_OPCODE'(r_wr_data[WORD_W-1 -: len_opcode]) == OP_HLT) begin
                            r_prog_done <= 1'b1;
                            r_loading   <= 1'b0;
                            r_state     <= ST_DONE;
                        end else if (r_addr == {len_addr{1'b1}}) begin
                            r_load_err <= 1'b1;
                            r_loading  <= 1'b0;
                            r_state    <= ST_ERROR;
                        end else begin
                            r_state <= ST_IDLE;
                        end
                    end
                end
                default: begin
                    r_state <= r_state;
                end
            endcase
        end
    end

    assign o_wr_en     = r_wr_en;
    assign o_wr_addr   = r_addr;
    assign o_wr_data   = r_wr_data;
    assign o_loading   = r_loading;
    assign o_prog_done = r_prog_done;
    assign o_load_err  = r_load_err;

endmodule

// File: tb/tb_bip_program_loader.sv
// Bench for bip_program_loader: full-size instance plus a 4-word instance for the overflow case.
module tb_bip_program_loader;

    localparam int unsigned TMO = 16;

    typedef struct {
        logic [10:0] addr;
        logic [15:0] data;
    } wr_t;

    typedef struct {
        logic [7:0]  hi;
        logic [7:0]  lo;
        logic [15:0] exp_data;
        logic        exp_done;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        a_reset, a_rx_done, a_wr_en, a_loading, a_prog_done, a_load_err;
    logic [7:0]  a_rx_data;
    logic [10:0] a_wr_addr;
    logic [15:0] a_wr_data;

    logic        b_reset, b_rx_done, b_wr_en, b_loading, b_prog_done, b_load_err;
    logic [7:0]  b_rx_data;
    logic [1:0]  b_wr_addr;
    logic [15:0] b_wr_data;

    int total = 0;
    int bad   = 0;
    wr_t qa[$];
    wr_t qb[$];
    vec_t vt[5];

    bip_program_loader #(.len_addr(11), .timeout_cycles(TMO)) dut_a (
        .i_clk(clk), .i_reset(a_reset), .i_rx_data(a_rx_data), .i_rx_done(a_rx_done),
        .o_wr_en(a_wr_en), .o_wr_addr(a_wr_addr), .o_wr_data(a_wr_data),
        .o_loading(a_loading), .o_prog_done(a_prog_done), .o_load_err(a_load_err)
    );

    bip_program_loader #(.len_addr(2), .timeout_cycles(TMO)) dut_b (
        .i_clk(clk), .i_reset(b_reset), .i_rx_data(b_rx_data), .i_rx_done(b_rx_done),
        .o_wr_en(b_wr_en), .o_wr_addr(b_wr_addr), .o_wr_data(b_wr_data),
        .o_loading(b_loading), .o_prog_done(b_prog_done), .o_load_err(b_load_err)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    // Every write strobe must match the oldest expected write of that instance.
    task automatic watch();
        wr_t e;
        if (a_wr_en) begin
            if (qa.size() == 0) begin
                total++;
                bad++;
                $display("FAIL a_unexpected_write: got addr=0x%0h data=0x%0h, required no write", a_wr_addr, a_wr_data);
            end else begin
                e = qa.pop_front();
                check("a_wr_addr", 32'(a_wr_addr), 32'(e.addr));
                check("a_wr_data", 32'(a_wr_data), 32'(e.data));
            end
        end
        if (b_wr_en) begin
            if (qb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL b_unexpected_write: got addr=0x%0h data=0x%0h, required no write", b_wr_addr, b_wr_data);
            end else begin
                e = qb.pop_front();
                check("b_wr_addr", 32'(b_wr_addr), 32'(e.addr));
                check("b_wr_data", 32'(b_wr_data), 32'(e.data));
            end
        end
    endtask

    task automatic cyc();
        @(negedge clk);
        watch();
    endtask

    task automatic idle(input int n);
        repeat (n) cyc();
    endtask

    task automatic send(input bit sel_b, input logic [7:0] v);
        if (sel_b) begin
            b_rx_data = v; b_rx_done = 1'b1;
        end else begin
            a_rx_data = v; a_rx_done = 1'b1;
        end
        cyc();
        a_rx_done = 1'b0;
        b_rx_done = 1'b0;
    endtask

    task automatic word(input bit sel_b, input logic [7:0] hi, input logic [7:0] lo);
        send(sel_b, hi);
        idle(2);
        send(sel_b, lo);
        idle(4);
    endtask

    task automatic reset_a();
        a_reset = 1'b0;
        cyc();
        a_reset = 1'b1;
    endtask

    initial begin
        vt[0] = '{hi: 8'h18, lo: 8'h05, exp_data: 16'h1805, exp_done: 1'b0};
        vt[1] = '{hi: 8'h20, lo: 8'h7F, exp_data: 16'h207F, exp_done: 1'b0};
        vt[2] = '{hi: 8'h3F, lo: 8'hFF, exp_data: 16'h3FFF, exp_done: 1'b0};
        vt[3] = '{hi: 8'h08, lo: 8'h10, exp_data: 16'h0810, exp_done: 1'b0};
        vt[4] = '{hi: 8'h00, lo: 8'h00, exp_data: 16'h0000, exp_done: 1'b1};

        a_reset = 1'b0; a_rx_done = 1'b0; a_rx_data = 8'h00;
        b_reset = 1'b0; b_rx_done = 1'b0; b_rx_data = 8'h00;
        idle(2);
        check("a_rst_wr_en",   32'(a_wr_en),     32'd0);
        check("a_rst_wr_addr", 32'(a_wr_addr),   32'd0);
        check("a_rst_wr_data", 32'(a_wr_data),   32'd0);
        check("a_rst_loading", 32'(a_loading),   32'd1);
        check("a_rst_done",    32'(a_prog_done), 32'd0);
        check("a_rst_err",     32'(a_load_err),  32'd0);
        check("b_rst_loading", 32'(b_loading),   32'd1);
        check("b_rst_err",     32'(b_load_err),  32'd0);
        a_reset = 1'b1;
        b_reset = 1'b1;
        idle(1);

        // LDI 5 then HLT, with exact write and prog_done timing
        qa.push_back('{addr: 11'd0, data: 16'h1805});
        word(1'b0, 8'h18, 8'h05);
        check("t1_err",  32'(a_load_err), 32'd0);
        check("t1_addr", 32'(a_wr_addr),  32'd1);
        qa.push_back('{addr: 11'd1, data: 16'h0000});
        send(1'b0, 8'h00);
        idle(2);
        send(1'b0, 8'h00);
        check("hlt_wr_en_n",    32'(a_wr_en),     32'd0);
        cyc();
        check("hlt_wr_en_n1",   32'(a_wr_en),     32'd1);
        check("hlt_done_n1",    32'(a_prog_done), 32'd0);
        check("hlt_loading_n1", 32'(a_loading),   32'd1);
        cyc();
        check("hlt_done_n2",    32'(a_prog_done), 32'd1);
        check("hlt_loading_n2", 32'(a_loading),   32'd0);
        check("hlt_err_n2",     32'(a_load_err),  32'd0);

        // Bytes after prog_done are ignored
        word(1'b0, 8'h08, 8'h01);
        check("post_done_addr", 32'(a_wr_addr),   32'd2);
        check("post_done_done", 32'(a_prog_done), 32'd1);
        check("post_done_err",  32'(a_load_err),  32'd0);

        // Table of valid words ending in HLT
        reset_a();
        for (int i = 0; i < 5; i++) begin
            qa.push_back('{addr: 11'(i), data: vt[i].exp_data});
            word(1'b0, vt[i].hi, vt[i].lo);
            check("vec_done", 32'(a_prog_done), 32'(vt[i].exp_done));
            check("vec_err",  32'(a_load_err),  32'd0);
            check("vec_addr", 32'(a_wr_addr),   32'(i + 1));
        end

        // Opcode 8 flags an error on the low-byte edge, no write
        reset_a();
        send(1'b0, 8'h40);
        idle(2);
        send(1'b0, 8'h01);
        check("inv_err",     32'(a_load_err), 32'd1);
        check("inv_loading", 32'(a_loading),  32'd0);
        check("inv_wr_en",   32'(a_wr_en),    32'd0);
        idle(4);
        word(1'b0, 8'h00, 8'h00);
        check("inv_done_after", 32'(a_prog_done), 32'd0);
        check("inv_err_after",  32'(a_load_err),  32'd1);

        // High byte discarded after exactly TMO idle cycles
        reset_a();
        send(1'b0, 8'h28);
        idle(TMO);
        qa.push_back('{addr: 11'd0, data: 16'h0803});
        word(1'b0, 8'h08, 8'h03);
        check("tmo_addr", 32'(a_wr_addr),  32'd1);
        check("tmo_err",  32'(a_load_err), 32'd0);

        // Low byte one edge before the timeout still pairs with the high byte
        qa.push_back('{addr: 11'd1, data: 16'h0844});
        send(1'b0, 8'h08);
        idle(TMO - 2);
        send(1'b0, 8'h44);
        idle(4);
        check("tmo_edge_addr", 32'(a_wr_addr), 32'd2);

        // Reset mid-word drops the partial word
        reset_a();
        send(1'b0, 8'h10);
        reset_a();
        qa.push_back('{addr: 11'd0, data: 16'h0000});
        word(1'b0, 8'h00, 8'h00);
        check("midrst_done", 32'(a_prog_done), 32'd1);
        check("midrst_addr", 32'(a_wr_addr),   32'd1);

        // 2-bit address space overflows after four non-Halt words
        for (int i = 0; i < 4; i++) begin
            qb.push_back('{addr: 11'(i), data: {5'(i + 1), 3'b000, 8'(i + 1)}});
            word(1'b1, 8'((i + 1) << 3), 8'(i + 1));
            check("ovf_err", 32'(b_load_err), (i == 3) ? 32'd1 : 32'd0);
        end
        check("ovf_loading", 32'(b_loading),   32'd0);
        check("ovf_done",    32'(b_prog_done), 32'd0);
        word(1'b1, 8'h28, 8'h05);
        check("ovf_err_hold", 32'(b_load_err), 32'd1);

        check("a_queue_empty", 32'(qa.size()), 32'd0);
        check("b_queue_empty", 32'(qb.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
